// File: rtl/exa_crosb_pkg.sv
// rtl/exa_crosb_pkg.sv - shared types and index helpers for the crossbar VC arbiters
package exa_crosb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        XFER    = 2'd2
    } arb_state_e;

    // Width of an index over n items; never zero so single-item configs still elaborate.
    function automatic int log2c(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int vc_index(input int prio, input int vc, input int vc_num);
        return prio * vc_num + vc;
    endfunction

endpackage

// File: rtl/exa_vc_rr_pick.sv
// rtl/exa_vc_rr_pick.sv - round-robin picker over the VCs of one priority class
module exa_vc_rr_pick
    import exa_crosb_pkg::*;
#(
    parameter int vc_num = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [vc_num-1:0]         req,
    input  logic [vc_num-1:0]         served,
    output logic                      pick_valid,
    output logic [log2c(vc_num)-1:0]  pick_idx
);

    localparam int PW = log2c(vc_num);

    logic [PW-1:0] ptr_q;

    // Scan from the farthest offset down so the request nearest the pointer wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = vc_num - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % vc_num]) begin
                pick_valid = 1'b1;
                pick_idx   = PW'((int'(ptr_q) + i) % vc_num);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < vc_num; i++) begin
                if (served[i]) begin
                    ptr_q <= PW'((i + 1) % vc_num);
                end
            end
        end
    end

endmodule

// File: rtl/exa_crosb_input_arbiter_vc.sv
// rtl/exa_crosb_input_arbiter_vc.sv - input-side VC select, request/grant handshake and wormhole lock
module exa_crosb_input_arbiter_vc
    import exa_crosb_pkg::*;
#(
    parameter int prio_num   = 2,
    parameter int vc_num     = 2,
    parameter int output_num = 4
) (
    input  logic                                                clk,
    input  logic                                                resetn,
    input  logic [prio_num*vc_num-1:0]                          i_vc_valid,
    input  logic [prio_num*vc_num-1:0]                          i_vc_last,
    input  logic [prio_num*vc_num-1:0][log2c(output_num)-1:0]   i_vc_dest,
    input  logic [prio_num*vc_num-1:0][output_num-1:0]          i_credit,
    input  logic [output_num-1:0]                               i_grant,
    output logic [output_num-1:0][prio_num*vc_num-1:0]          o_request,
    output logic                                                o_cts,
    output logic                                                o_last,
    output logic [prio_num*vc_num-1:0]                          o_vc_pop,
    output logic [log2c(prio_num*vc_num)-1:0]                   o_vc_sel,
    output logic [log2c(output_num)-1:0]                        o_output_sel
);

    localparam int NVC = prio_num * vc_num;
    localparam int VW  = log2c(NVC);
    localparam int OW  = log2c(output_num);
    localparam int PW  = log2c(vc_num);

    arb_state_e     state_q;
    logic [VW-1:0]  vc_sel_q;
    logic [OW-1:0]  out_sel_q;
    logic           mid_pkt_q;

    logic [NVC-1:0]               eligible;
    logic [NVC-1:0]               served;
    logic [prio_num-1:0]          class_any;
    logic [prio_num-1:0][PW-1:0]  class_idx;
    logic [VW-1:0]                win_vc;
    logic                         lock_ok;
    logic                         cts;
    logic                         beat_last;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NVC; k++) begin
            eligible[k] = i_vc_valid[k] & i_credit[k][i_vc_dest[k]];
        end
    end

    for (genvar p = 0; p < prio_num; p++) begin : g_class
        exa_vc_rr_pick #(
            .vc_num     (vc_num)
        ) u_pick (
            .clk        (clk),
            .resetn     (resetn),
            .req        (eligible[p*vc_num +: vc_num]),
            .served     (served[p*vc_num +: vc_num]),
            .pick_valid (class_any[p]),
            .pick_idx   (class_idx[p])
        );
    end

    // Later (higher) classes overwrite earlier ones, so the top non-empty class wins.
    always_comb begin
        win_vc = '0;
        for (int p = 0; p < prio_num; p++) begin
            if (class_any[p]) begin
                win_vc = VW'(vc_index(p, int'(class_idx[p]), vc_num));
            end
        end
    end

    assign lock_ok   = i_vc_valid[vc_sel_q] & i_credit[vc_sel_q][out_sel_q];
    assign cts       = (state_q == XFER) & lock_ok;
    assign beat_last = cts & i_vc_last[vc_sel_q];

    always_comb begin
        o_request = '0;
        o_vc_pop  = '0;
        if (state_q == REQUEST) begin
            o_request[out_sel_q][vc_sel_q] = 1'b1;
        end
        o_vc_pop[vc_sel_q] = cts;
    end

    assign served       = beat_last ? o_vc_pop : '0;
    assign o_cts        = cts;
    assign o_last       = beat_last;
    assign o_vc_sel     = vc_sel_q;
    assign o_output_sel = out_sel_q;

    // A stalled packet must go back through REQUEST because the output arbiter drops on !cts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            vc_sel_q  <= '0;
            out_sel_q <= '0;
            mid_pkt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|eligible) begin
                        vc_sel_q  <= win_vc;
                        out_sel_q <= i_vc_dest[win_vc];
                        state_q   <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (i_grant[out_sel_q]) begin
                        state_q <= XFER;
                    end else if (!lock_ok && !mid_pkt_q) begin
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if (beat_last) begin
                        state_q   <= IDLE;
                        mid_pkt_q <= 1'b0;
                    end else if (!cts) begin
                        state_q   <= REQUEST;
                        mid_pkt_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
